// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : 32x32 MIPS general-purpose register file. One write port with
//            one-hot decoded enables, two combinational read ports, register
//            0 hard-wired to zero, optional same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  // Stored view of every register; entry 0 is a constant zero, not a flop.
  logic [DATA_W-1:0] w_array [c_DEPTH];

  // A write to a nonzero index is in flight this cycle (and not masked by reset).
  logic w_wr_active;
  logic w_byp1;
  logic w_byp2;

  assign w_wr_active = !rst && reg_write && (write_reg != '0);

  for (genvar i = 0; i < c_DEPTH; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign w_array[i] = '0;
    end else begin : g_store
      logic              w_we;
      logic [DATA_W-1:0] r_q;

      assign w_we = reg_write && (write_reg == ADDR_W'(i));

      // Reset clears the register and wins over a simultaneous write.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_we) begin
          r_q <= write_data;
        end
      end

      assign w_array[i] = r_q;
    end
  end

  // Bypass is only meaningful for a live, nonzero write; index 0 never matches
  // because w_wr_active already excludes write_reg == 0.
  if (BYPASS != 0) begin : g_bypass
    assign w_byp1 = w_wr_active && (read_reg1 == write_reg);
    assign w_byp2 = w_wr_active && (read_reg2 == write_reg);
  end else begin : g_no_bypass
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
  end

  // Combinational read ports: forwarded write data or the stored array entry.
  always_comb begin
    read_data1 = w_array[read_reg1];
    read_data2 = w_array[read_reg2];
    if (w_byp1) begin
      read_data1 = write_data;
    end
    if (w_byp2) begin
      read_data2 = write_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Write-side counterpart to the datapath's 2:1 and 4:1 operand/destination muxes. It is the 32×32 MIPS general-purpose register file. A 5-bit destination index (the output of the RegDst 5-bit mux) is decoded into one of 32 write enables, and the write-back value (the output of the MemtoReg mux) is stored on the clock edge. Two read ports feed the ALU-source and branch-compare muxes. It sits between the write-back selection muxes and the decode/execute operand path.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth is 2**ADDR_W
- BYPASS, 1, when 1 a read of the register being written this cycle returns the new write_data

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- reg_write  input  1  write enable from control
- write_reg  input  ADDR_W  destination register index
- write_data  input  DATA_W  write-back value
- read_reg1  input  ADDR_W  read port 1 index (rs)
- read_reg2  input  ADDR_W  read port 2 index (rt)
- read_data1  output  DATA_W  read port 1 data
- read_data2  output  DATA_W  read port 2 data

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits.
- Write decode:
  - The write index is decoded one-hot into per-register enables.
  - Enable[i] = reg_write && (write_reg == i) && (i != 0).
  - Exactly zero or one register updates per edge.
- Register 0 ($zero):
  - Never written.
  - Always reads 0, including via bypass.
  - A write to index 0 is silently discarded.
- Reads: combinational. Each port selects the addressed register. If the index is 0, the port returns 0.
- Bypass (BYPASS=1): if rst=0, reg_write=1, write_reg != 0 and read_regN == write_reg, then read_dataN = write_data in the same cycle. Otherwise the port returns the stored value.
- BYPASS=0: reads always return the stored value. A same-cycle write becomes visible after the edge.
- Both ports may address the same register and return identical data.
- Reset:
  - When rst=1 at a rising edge, every register is cleared to 0.
  - Reset has priority over any simultaneous write; the write is lost.
  - While rst=1, bypass is suppressed and reads return stored values.

## Timing
- Write latency: data is stored at the first rising edge with reg_write=1. It is visible through the array from the cycle after that edge.
- Read latency: 0 cycles (combinational from the indices, the array, and, with BYPASS=1, the write inputs).
- Reset values: after the reset edge all registers are 0, so read_data1 = read_data2 = 0 for any index until the first write.
- Before the first reset edge, register contents (other than index 0) are undefined (X).
- Reset mid-operation:
  - Reset asserted in the same cycle as a write: the write is discarded and the register reads 0 afterwards.
  - Reset held for multiple cycles: all writes are ignored.
- Back-to-back writes to the same index: the last edge wins. Each intermediate value is visible for one cycle.
- No internal delays. Outputs change only with inputs or at clock edges, with no #-delay in the block itself.

## Test plan
- Reset then read:
  - Stimulus: pulse rst=1 for 1 cycle, then sweep read_reg1/read_reg2 over 0..31.
  - Required: all reads return 0x00000000.
- Write and read back:
  - Stimulus: write 0xDEADBEEF to reg 8, then 0x12345678 to reg 31 on consecutive cycles.
  - Required: next cycle read_reg1=8 → 0xDEADBEEF and read_reg2=31 → 0x12345678. Reg 9 still reads 0.
- $zero protection:
  - Stimulus: reg_write=1, write_reg=0, write_data=0xFFFFFFFF, with read_reg1=0 in the same and the next cycle.
  - Required: read_data1=0 in both cycles. No other register changes.
- Bypass:
  - Stimulus: with BYPASS=1, reg 5 holds 0x11, then write 0x22 to reg 5 with read_reg1=read_reg2=5.
  - Required: both ports read 0x22 in the write cycle itself.
  - Variant: with BYPASS=0, the ports read 0x11 in the write cycle and 0x22 after the edge.
- Write disabled:
  - Stimulus: reg_write=0, write_reg=7, write_data=0xAAAA5555 over several edges.
  - Required: reg 7 keeps its prior value. No bypass with BYPASS=1.
- Reset collision:
  - Stimulus: reg 3 holds 0x55. In one cycle assert rst=1 and write 0x99 to reg 3, with read_reg1=3.
  - Required: during that cycle read_data1=0x55 (no bypass). After the edge reg 3 reads 0 and the 0x99 write is lost.
